// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: two's-complement adder/subtractor built as STAGES registered, carry-chained
//   SLICE-bit ripple slices (SLICE = WIDTH/STAGES). The add or subtract presented while in_ready=1
//   appears STAGES clock edges later.
// Backpressure: a single global advance (adv = ~out_valid | out_ready) moves or holds every stage
//   together. in_ready = adv. A full pipe with out_ready=0 stalls without dropping an operation.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   A, B [WIDTH]        operands
//   Cin                 carry-in, used only when Sub=0
//   Sub                 1: A-B, 0: A+B+Cin
//   in_valid/in_ready   operand handshake
//   Sum [WIDTH], Cout   result; Cout is the carry-out, or no-borrow when subtracting
//   out_valid/out_ready result handshake
//   V                   signed overflow, present only when OVERFLOW_FLAG_EN is defined
//
// Optional feature macro: OVERFLOW_FLAG_EN adds output V, which is registered alongside Sum.
module pipelined_add_sub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             V
`endif
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic adv;

  // Stage registers. a_q/b_q carry the operands forward so that later stages can reach their
  // slices. s_q accumulates the result slices that have been computed so far.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             vld_q [STAGES];

  // Per-stage inputs: stage 0 takes the prepared operands, and stage k takes the register of
  // stage k-1.
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] s_src   [STAGES];
  logic             c_src   [STAGES];
  logic             vld_src [STAGES];

  logic [SLICE:0]   slice_sum [STAGES];
  logic [WIDTH-1:0] s_d       [STAGES];
  logic             c_d       [STAGES];

  assign adv       = ~vld_q[LAST] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign Sum       = s_q[LAST];
  assign Cout      = c_q[LAST];

  // When subtracting, the operand prep computes A + ~B + 1. In that case, Cin has no effect.
  always_comb begin
    a_src[0]   = A;
    b_src[0]   = Sub ? ~B : B;
    c_src[0]   = Sub ? 1'b1 : Cin;
    s_src[0]   = '0;
    vld_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = s_q[k-1];
      c_src[k]   = c_q[k-1];
      vld_src[k] = vld_q[k-1];
    end
  end

  // Each slice is added at SLICE+1 bits, so its carry-out is the top bit of that sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_src[k][k*SLICE +: SLICE]}
                   + {1'b0, b_src[k][k*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, c_src[k]};
      s_d[k] = s_src[k];
      s_d[k][k*SLICE +: SLICE] = slice_sum[k][SLICE-1:0];
      c_d[k] = slice_sum[k][SLICE];
    end
  end

  // A bubble moves only its valid bit. The data registers keep their old contents, so Sum and
  // Cout hold their last value while out_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_src[k];
        if (vld_src[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  // The carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
  // Overflow is that carry XOR the final carry-out.
  logic msb_cin;
  logic ovf_d;
  logic ovf_q;

  assign msb_cin = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1];
  assign ovf_d   = msb_cin ^ c_d[LAST];
  assign V       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv && vld_src[LAST]) begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed testbench for pipelined_add_sub with WIDTH=8 and STAGES=2. A second instance with
// WIDTH=16 and STAGES=4 exercises V when OVERFLOW_FLAG_EN is defined.
// Inputs change 1 time unit after each rising edge. Outputs are checked at that same point.
module tb_pipelined_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin, sub, in_valid, in_ready, out_ready;
  logic [7:0] sum;
  logic       cout, out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sub(sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sum(sum), .Cout(cout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef OVERFLOW_FLAG_EN
    , .V()
`endif
  );

`ifdef OVERFLOW_FLAG_EN
  logic [15:0] a16, b16, sum16;
  logic        sub16, in_valid16, in_ready16, cout16, out_valid16, v16;

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(1'b0), .Sub(sub16),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .Sum(sum16), .Cout(cout16), .out_valid(out_valid16), .out_ready(1'b1), .V(v16)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
  endtask

  task automatic res(input string tag, input logic [7:0] s, input logic c);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, s});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic s, input logic [15:0] exp_sum, input logic exp_v);
    a16 = av; b16 = bv; sub16 = s; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    tick(); tick();
    chk({tag, "_early"}, {31'd0, out_valid16}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'd0, out_valid16}, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum16}, {16'd0, exp_sum});
    chk({tag, "_v"}, {31'd0, v16}, {31'd0, exp_v});
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    idle();
`ifdef OVERFLOW_FLAG_EN
    a16 = '0; b16 = '0; sub16 = 1'b0; in_valid16 = 1'b0;
`endif
    tick();
    rst = 1'b0;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of operation: both operations are discarded.
    put(8'h01, 8'h01, 1'b0, 1'b0); tick();
    put(8'h02, 8'h03, 1'b0, 1'b0); tick();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_vld", {31'd0, out_valid}, 32'd0);
    chk("mrst_sum", {24'd0, sum}, 32'd0);
    chk("mrst_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back adds. Each result appears two edges after its operands are presented.
    put(8'h01, 8'h01, 1'b0, 1'b0); tick();
    chk("add_lat", {31'd0, out_valid}, 32'd0);
    put(8'h02, 8'h03, 1'b0, 1'b0); tick(); res("add01", 8'h02, 1'b0);
    put(8'h81, 8'h81, 1'b0, 1'b0); tick(); res("add02", 8'h05, 1'b0);
    put(8'h19, 8'h31, 1'b0, 1'b0); tick(); res("add81", 8'h02, 1'b1);
    idle();                        tick(); res("add19", 8'h4A, 1'b0);
    tick();
    chk("bub_vld", {31'd0, out_valid}, 32'd0);
    chk("bub_hold", {24'd0, sum}, 32'h4A);

    // Carry crossing the slice boundary.
    put(8'hFF, 8'h01, 1'b0, 1'b0); tick();
    put(8'hFF, 8'h00, 1'b0, 1'b0); tick(); res("ffp01", 8'h00, 1'b1);
    put(8'hFF, 8'hFF, 1'b1, 1'b0); tick(); res("ffp00", 8'hFF, 1'b0);
    idle();                        tick(); res("ffpff_c", 8'hFF, 1'b1);
    tick();

    // Subtract. Cin is ignored in this mode.
    put(8'h05, 8'h03, 1'b0, 1'b1); tick();
    put(8'h03, 8'h05, 1'b1, 1'b1); tick(); res("sub53", 8'h02, 1'b1);
    put(8'h0A, 8'h0A, 1'b1, 1'b1); tick(); res("sub35", 8'hFE, 1'b0);
    idle();                        tick(); res("subaa", 8'h00, 1'b1);
    tick();

    // Backpressure: three operations are issued while out_ready=0.
    out_ready = 1'b0;
    put(8'h11, 8'h22, 1'b0, 1'b0); tick();
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    put(8'h33, 8'h44, 1'b0, 1'b0); tick();
    chk("bp_rdy2", {31'd0, in_ready}, 32'd0);
    res("bp_head", 8'h33, 1'b0);
    put(8'h55, 8'h66, 1'b0, 1'b0); tick();
    chk("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
    res("bp_stall1", 8'h33, 1'b0);
    tick();
    res("bp_stall2", 8'h33, 1'b0);
    out_ready = 1'b1; #1;
    chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    res("bp_op2", 8'h77, 1'b0);
    idle(); tick();
    res("bp_op3", 8'hBB, 1'b0);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

`ifdef OVERFLOW_FLAG_EN
    op16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
    op16("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
    op16("ovf_none", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
